// File: rtl/instr_encoder_loader.sv
// Streaming RV32I instruction encoder and instruction-SRAM writer.
// Takes decoded fields over valid/ready, range/alignment-checks the
// immediate, packs the architectural instruction word and writes it to
// consecutive word addresses starting at the session base address.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  last_i,
  input  logic [6:0]            op_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [31:0]           imm_i,
  output logic                  im_we_o,
  output logic [ADDR_WIDTH-1:0] im_addr_o,
  output logic [31:0]           im_wdata_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_RANGE  = 2'd2;
  localparam logic [1:0] ERR_ALIGN  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  last_r;
  logic [1:0]            enc_err_s;
  logic [31:0]           enc_word_s;

  // Pack fields into the instruction word; returns {error_code, word}.
  // Misalignment outranks range so a bad offset is reported as such.
  function automatic logic [33:0] encode_fields(
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic [1:0]  c;
    logic        i_ok;
    logic        b_ok;
    logic        j_ok;
    i_ok = (&imm[31:11]) | ~(|imm[31:11]);
    b_ok = (&imm[31:12]) | ~(|imm[31:12]);
    j_ok = (&imm[31:20]) | ~(|imm[31:20]);
    w    = 32'd0;
    c    = ERR_NONE;
    case (op)
      OP_OP: begin
        w = {f7, rs2, rs1, f3, rd, op};
        c = ERR_NONE;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        w = {imm[11:0], rs1, f3, rd, op};
        c = i_ok ? ERR_NONE : ERR_RANGE;
      end
      OP_STORE: begin
        w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        c = i_ok ? ERR_NONE : ERR_RANGE;
      end
      OP_BRANCH: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        if (imm[0]) c = ERR_ALIGN;
        else if (!b_ok) c = ERR_RANGE;
        else c = ERR_NONE;
      end
      OP_LUI, OP_AUIPC: begin
        w = {imm[31:12], rd, op};
        c = (imm[11:0] == 12'd0) ? ERR_NONE : ERR_RANGE;
      end
      OP_JAL: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        if (imm[0]) c = ERR_ALIGN;
        else if (!j_ok) c = ERR_RANGE;
        else c = ERR_NONE;
      end
      default: begin
        w = 32'd0;
        c = ERR_OPCODE;
      end
    endcase
    return {c, w};
  endfunction

  // Combinational encode/check of the bundle currently on the inputs.
  always_comb begin
    {enc_err_s, enc_word_s} = encode_fields(op_i, rd_i, rs1_i, rs2_i,
                                            funct3_i, funct7_i, imm_i);
  end

  // Session FSM with all outputs registered; write pulse lives only in WRITE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      last_r     <= 1'b0;
      in_ready_o <= 1'b0;
      im_we_o    <= 1'b0;
      im_addr_o  <= {ADDR_WIDTH{1'b0}};
      im_wdata_o <= 32'd0;
      count_o    <= {(ADDR_WIDTH+1){1'b0}};
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
    end else begin
      im_we_o <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state_r    <= S_ACCEPT;
            addr_r     <= base_addr_i;
            count_o    <= {(ADDR_WIDTH+1){1'b0}};
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            in_ready_o <= 1'b1;
          end
        end
        S_ACCEPT: begin
          if (in_valid_i && in_ready_o) begin
            in_ready_o <= 1'b0;
            if (enc_err_s == ERR_NONE) begin
              state_r    <= S_WRITE;
              im_we_o    <= 1'b1;
              im_addr_o  <= addr_r;
              im_wdata_o <= enc_word_s;
              last_r     <= last_i;
            end else begin
              state_r    <= S_ERR;
              err_o      <= 1'b1;
              err_code_o <= enc_err_s;
            end
          end
        end
        S_WRITE: begin
          addr_r  <= addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          count_o <= count_o + {{ADDR_WIDTH{1'b0}}, 1'b1};
          if (last_r) begin
            state_r <= S_DONE;
            done_o  <= 1'b1;
          end else if (&addr_r) begin
            // Next address would wrap onto the start of memory.
            state_r    <= S_ERR;
            err_o      <= 1'b1;
            err_code_o <= ERR_RANGE;
          end else begin
            state_r    <= S_ACCEPT;
            in_ready_o <= 1'b1;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          in_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader with a write scoreboard.
module tb_instr_encoder_loader;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          last_i;
  logic [6:0]    op_i;
  logic [4:0]    rd_i, rs1_i, rs2_i;
  logic [2:0]    funct3_i;
  logic [6:0]    funct7_i;
  logic [31:0]   imm_i;
  logic          im_we_o;
  logic [AW-1:0] im_addr_o;
  logic [31:0]   im_wdata_o;
  logic [AW:0]   count_o;
  logic          done_o, err_o;
  logic [1:0]    err_code_o;

  int errors = 0;
  int checks = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] got_q[$];
  logic [AW-1:0]  exp_addr;

  instr_encoder_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .last_i(last_i),
    .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .im_we_o(im_we_o), .im_addr_o(im_addr_o), .im_wdata_o(im_wdata_o),
    .count_o(count_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample just after the edge, log any SRAM write.
  task automatic tick();
    @(posedge clk);
    #1;
    if (im_we_o === 1'b1) got_q.push_back({im_addr_o, im_wdata_o});
  endtask

  task automatic start(input logic [AW-1:0] base);
    base_addr_i = base;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    exp_addr = base;
    chk("start_ready", {31'd0, in_ready_o}, 32'd1);
    chk("start_flags", {29'd0, done_o, err_o, err_code_o == 2'd0}, 32'd1);
  endtask

  // Offer one bundle; on ok, expect the write pulse in the next cycle.
  task automatic send(input string tag, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic last,
                      input logic ok, input logic [31:0] word);
    op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; funct3_i = f3;
    funct7_i = f7; imm_i = imm; last_i = last; in_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (in_ready_o === 1'b1) break;
      tick();
    end
    chk({tag, "_ready_hi"}, {31'd0, in_ready_o}, 32'd1);
    if (ok) begin
      exp_q.push_back({exp_addr, word});
      exp_addr = exp_addr + 14'd1;
    end
    tick();
    in_valid_i = 1'b0;
    chk({tag, "_we"}, {31'd0, im_we_o}, {31'd0, ok});
    chk({tag, "_ready_lo"}, {31'd0, in_ready_o}, 32'd0);
  endtask

  // Compare every logged write against the scoreboard, then empty both.
  task automatic drain(input string tag);
    chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [AW+31:0] e;
      logic [AW+31:0] g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_addr"}, {18'd0, g[AW+31:32]}, {18'd0, e[AW+31:32]});
      chk({tag, "_data"}, g[31:0], e[31:0]);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic chk_end(input string tag, input logic done, input logic err,
                         input logic [1:0] code, input logic [AW:0] cnt);
    chk({tag, "_done"}, {31'd0, done_o}, {31'd0, done});
    chk({tag, "_err"}, {31'd0, err_o}, {31'd0, err});
    chk({tag, "_code"}, {30'd0, err_code_o}, {30'd0, code});
    chk({tag, "_count"}, {17'd0, count_o}, {17'd0, cnt});
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; in_valid_i = 1'b0; last_i = 1'b0;
    op_i = 7'd0; rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0; funct3_i = 3'd0;
    funct7_i = 7'd0; imm_i = 32'd0; exp_addr = '0;
    tick(); tick();
    chk("rst_ready", {31'd0, in_ready_o}, 32'd0);
    chk("rst_we", {31'd0, im_we_o}, 32'd0);
    chk("rst_addr", {18'd0, im_addr_o}, 32'd0);
    chk("rst_wdata", im_wdata_o, 32'd0);
    chk_end("rst", 1'b0, 1'b0, 2'd0, 15'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", {31'd0, in_ready_o}, 32'd0);

    // ADDI x1,x0,-1
    start(14'h10);
    send("addi", 7'b0010011, 5'd1, 5'd0, 5'd7, 3'd0, 7'h55, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFF00093);
    tick();
    chk_end("addi", 1'b1, 1'b0, 2'd0, 15'd1);
    chk("addi_ready_done", {31'd0, in_ready_o}, 32'd0);
    drain("addi");

    // SW x2,-4(x3) then BEQ x0,x0,+8
    start(14'h20);
    send("sw", 7'b0100011, 5'd9, 5'd3, 5'd2, 3'd2, 7'h00, 32'hFFFFFFFC, 1'b0, 1'b1, 32'hFE21AE23);
    tick();
    send("beq", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 1'b1, 1'b1, 32'h00000463);
    tick();
    chk_end("swbeq", 1'b1, 1'b0, 2'd0, 15'd2);
    drain("swbeq");

    // JAL x1,+2048 then LUI x5,0x12345000
    start(14'h30);
    send("jal", 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 1'b0, 1'b1, 32'h001000EF);
    tick();
    send("lui", 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b1, 1'b1, 32'h123452B7);
    tick();
    chk_end("jallui", 1'b1, 1'b0, 2'd0, 15'd2);
    drain("jallui");

    // Error sessions
    start(14'h40);
    send("e_addi", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 1'b0, 1'b0, 32'd0);
    chk_end("e_addi", 1'b0, 1'b1, 2'd2, 15'd0);
    start(14'h40);
    send("e_beq", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000003, 1'b0, 1'b0, 32'd0);
    chk_end("e_beq", 1'b0, 1'b1, 2'd3, 15'd0);
    start(14'h40);
    send("e_op", 7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000001, 1'b0, 1'b0, 32'd0);
    chk_end("e_op", 1'b0, 1'b1, 2'd1, 15'd0);
    start(14'h40);
    send("e_lui", 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 1'b0, 1'b0, 32'd0);
    chk_end("e_lui", 1'b0, 1'b1, 2'd2, 15'd0);
    start(14'h40);
    send("e_prio", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001001, 1'b0, 1'b0, 32'd0);
    chk_end("e_prio", 1'b0, 1'b1, 2'd3, 15'd0);
    tick();
    drain("errs");

    // Wrap at the top address with a second bundle waiting
    start(14'h3FFF);
    send("wrap", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000005, 1'b0, 1'b1, 32'h00500093);
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wrap_ready", {31'd0, in_ready_o}, 32'd0);
    end
    in_valid_i = 1'b0;
    chk_end("wrap", 1'b0, 1'b1, 2'd2, 15'd1);
    drain("wrap");

    // Reset while in WRITE
    start(14'h40);
    send("rstw", 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000001, 1'b0, 1'b1, 32'h00100113);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstw_we", {31'd0, im_we_o}, 32'd0);
    chk("rstw_ready", {31'd0, in_ready_o}, 32'd0);
    chk_end("rstw", 1'b0, 1'b0, 2'd0, 15'd0);
    start(14'h50);
    send("post", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFF00093);
    tick();
    chk_end("post", 1'b1, 1'b0, 2'd0, 15'd1);
    drain("rstw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
